// File: rtl/vga_scene_if.sv
// vga_scene_if: game-logic inputs and VGA outputs of the scene renderer.
interface vga_scene_if;
   logic [11:0] x_begin, y_begin, p_x;
   logic [3:0]  score, miss;
   logic        end_show;
   logic        hsync, vsync, frame_tick;
   logic [3:0]  vga_r, vga_g, vga_b;
   modport master (output x_begin, y_begin, p_x, score, miss, end_show,
                   input hsync, vsync, frame_tick, vga_r, vga_g, vga_b);
   modport slave  (input x_begin, y_begin, p_x, score, miss, end_show,
                   output hsync, vsync, frame_tick, vga_r, vga_g, vga_b);
endinterface

// File: rtl/vga_scene.sv
// vga_scene: VGA raster renderer that paints the object, paddle and end screen from per-frame shadow copies of its inputs.
// Defining VGA_SCORE_BAR_EN adds the score and miss bars.
module vga_scene #(
   parameter int CLK_DIV = 4,
   parameter int OBJ_W   = 40,
   parameter int OBJ_H   = 40,
   parameter int PAD_W   = 100,
   parameter int PAD_Y   = 380,
   parameter int PAD_H   = 10,
   parameter int H_VIS   = 640,
   parameter int H_FP    = 16,
   parameter int H_SYNC  = 96,
   parameter int H_BP    = 48,
   parameter int V_VIS   = 480,
   parameter int V_FP    = 10,
   parameter int V_SYNC  = 2,
   parameter int V_BP    = 33
) (
   input logic clk,
   input logic rst,
   vga_scene_if.slave bus
);
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [9:0] HV = 10'(H_VIS), HS0 = 10'(H_VIS + H_FP), HS1 = 10'(H_VIS + H_FP + H_SYNC);
   localparam logic [9:0] HL = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
   localparam logic [9:0] VV = 10'(V_VIS), VS0 = 10'(V_VIS + V_FP), VS1 = 10'(V_VIS + V_FP + V_SYNC);
   localparam logic [9:0] VL = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
   localparam logic [12:0] OW = 13'(OBJ_W), OH = 13'(OBJ_H), PW = 13'(PAD_W);
   localparam logic [12:0] PY0 = 13'(PAD_Y), PY1 = 13'(PAD_Y + PAD_H);
   logic [DW-1:0] div;
   logic [9:0]    h, v;
   logic [11:0]   sx, sy, sp;
   logic [3:0]    ss, sm;
   logic          se;
   logic          pix_en, load, vis, obj, pad, bar_s, bar_m;
   logic [12:0]   h13, v13;
   logic [11:0]   rgb_n;
   assign pix_en = div == DIV_LAST;
   assign load   = pix_en && h == 10'd0 && v == VV;
   assign h13    = {3'b0, h};
   assign v13    = {3'b0, v};
   assign vis    = h < HV && v < VV;
   // 13-bit sums keep coordinates near 4095 from wrapping back onto the screen
   assign obj = h13 >= {1'b0, sx} && h13 < {1'b0, sx} + OW && v13 >= {1'b0, sy} && v13 < {1'b0, sy} + OH;
   assign pad = h13 >= {1'b0, sp} && h13 < {1'b0, sp} + PW && v13 >= PY0 && v13 < PY1;
`ifdef VGA_SCORE_BAR_EN
   assign bar_s = v >= 10'd8  && v <= 10'd15 && h >= 10'd8 && h13 < 13'd8 + {5'b0, ss, 4'b0};
   assign bar_m = v >= 10'd20 && v <= 10'd27 && h >= 10'd8 && h13 < 13'd8 + {5'b0, sm, 4'b0};
`else
   logic unused_bar;
   assign unused_bar = ^{ss, sm};
   assign bar_s = 1'b0;
   assign bar_m = 1'b0;
`endif
   assign rgb_n = !vis ? 12'h000 : se ? 12'h400 : bar_s ? 12'h0F0 : bar_m ? 12'hF00 :
                  obj ? 12'hFF0 : pad ? 12'h0FF : 12'h000;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         div            <= '0;
         h              <= '0;
         v              <= '0;
         {sx, sy, sp}   <= '0;
         {ss, sm, se}   <= '0;
         bus.hsync      <= 1'b1;
         bus.vsync      <= 1'b1;
         bus.frame_tick <= 1'b0;
         {bus.vga_r, bus.vga_g, bus.vga_b} <= '0;
      end else begin
         div            <= pix_en ? '0 : div + 1'b1;
         bus.frame_tick <= load;
         if (pix_en) begin
            h         <= h == HL ? 10'd0 : h + 10'd1;
            if (h == HL) v <= v == VL ? 10'd0 : v + 10'd1;
            bus.hsync <= !(h >= HS0 && h < HS1);
            bus.vsync <= !(v >= VS0 && v < VS1);
            {bus.vga_r, bus.vga_g, bus.vga_b} <= rgb_n;
         end
         if (load) begin
            {sx, sy, sp} <= {bus.x_begin, bus.y_begin, bus.p_x};
            {ss, sm, se} <= {bus.score, bus.miss, bus.end_show};
         end
      end
endmodule

// File: tb/tb_vga_scene.sv
// tb_vga_scene: randomized check of vga_scene on a reduced raster against a pixel-index reference model.
module tb_vga_scene;
   localparam int CD = 2, HV = 64, HF = 4, HS = 8, HB = 4, VV = 48, VF = 2, VS = 2, VB = 3;
   localparam int OW = 8, OH = 6, PW = 12, PY = 40, PH = 3;
   localparam int HT = HV + HF + HS + HB, VT = VV + VF + VS + VB;
   logic clk = 1'b0, rst = 1'b0;
   vga_scene_if bus ();
   vga_scene #(.CLK_DIV(CD), .OBJ_W(OW), .OBJ_H(OH), .PAD_W(PW), .PAD_Y(PY), .PAD_H(PH),
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB), .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB))
      dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   int checks = 0, failures = 0;
   int c_x, c_y, c_p, c_s, c_m, c_e;
   int s_x, s_y, s_p, s_s, s_m, s_e;
   int e_hs, e_vs, e_rgb, k, last_tick, yellow_seen;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
      end
   endtask
   function automatic int pick(input int lim);
      int r = $urandom_range(0, 9);
      return r < 7 ? $urandom_range(0, lim) : r == 7 ? 4095 : lim - 12;
   endfunction
   task automatic drive_random();
      c_x = pick(HV + 8);
      c_y = pick(VV + 6);
      c_p = pick(HV + 8);
      c_s = $urandom_range(0, 15);
      c_m = $urandom_range(0, 15);
      c_e = $urandom_range(0, 7) == 0;
      bus.x_begin = 12'(c_x);
      bus.y_begin = 12'(c_y);
      bus.p_x = 12'(c_p);
      bus.score = 4'(c_s);
      bus.miss = 4'(c_m);
      bus.end_show = c_e[0];
   endtask
   function automatic int colour(input int h, input int v);
      if (h >= HV || v >= VV) return 0;
      if (s_e != 0) return 'h400;
`ifdef VGA_SCORE_BAR_EN
      if (v >= 8 && v <= 15 && h >= 8 && h < 8 + 16 * s_s) return 'h0F0;
      if (v >= 20 && v <= 27 && h >= 8 && h < 8 + 16 * s_m) return 'hF00;
`endif
      if (h >= s_x && h < s_x + OW && v >= s_y && v < s_y + OH) return 'hFF0;
      if (h >= s_p && h < s_p + PW && v >= PY && v < PY + PH) return 'h0FF;
      return 0;
   endfunction
   function automatic bit is_load(input int kk);
      int q = kk / CD - 1;
      return kk % CD == 0 && q % HT == 0 && (q / HT) % VT == VV;
   endfunction
   task automatic reset_model();
      {s_x, s_y, s_p, s_s, s_m, s_e} = '0;
      e_hs = 1; e_vs = 1; e_rgb = 0; k = 0; last_tick = -1;
   endtask
   task automatic check_outputs(input int ft);
      check("hsync", 32'(bus.hsync), e_hs);
      check("vsync", 32'(bus.vsync), e_vs);
      check("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), e_rgb);
      check("frame_tick", 32'(bus.frame_tick), ft);
   endtask
   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         int ft = 0;
         @(posedge clk);
         #1;
         k++;
         if (k % CD == 0) begin
            int q = k / CD - 1;
            int h = q % HT;
            int v = (q / HT) % VT;
            e_hs = !(h >= HV + HF && h < HV + HF + HS);
            e_vs = !(v >= VV + VF && v < VV + VF + VS);
            e_rgb = colour(h, v);
            if (is_load(k)) begin
               ft = 1;
               {s_x, s_y, s_p, s_s, s_m, s_e} = {c_x, c_y, c_p, c_s, c_m, c_e};
            end
         end
         check_outputs(ft);
         if ({bus.vga_r, bus.vga_g, bus.vga_b} == 12'hFF0) yellow_seen++;
         if (ft != 0) begin
            if (last_tick >= 0) check("tick_period", k - last_tick, HT * VT * CD);
            last_tick = k;
         end
         // changes right before a load edge must still be captured
         if ($urandom_range(0, 599) == 0 || (is_load(k + 1) && $urandom_range(0, 1) == 1)) drive_random();
      end
   endtask
   initial begin
      yellow_seen = 0;
      drive_random();
      reset_model();
      repeat (3) @(posedge clk);
      #1;
      check_outputs(0);
      @(negedge clk);
      rst = 1'b1;
      run(4 * HT * VT * CD + 50);
      #2;
      rst = 1'b0;
      #1;
      reset_model();
      check_outputs(0);
      @(negedge clk);
      rst = 1'b1;
      run(2 * HT * VT * CD + HT * 10);
      check("yellow_seen", 32'(yellow_seen > 0), 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
